// File: rtl/systolic_seq_ctrl.sv
// Phase sequencer for the systolic array: LOAD_W / FEED / SKEW / COLLECT / DRAIN per tile.
// Define SYSCTRL_PERF_EN to add the perf_cycles / perf_stalls counters.
module systolic_seq_ctrl #(
  parameter int ARRAY_H = 4,
  parameter int ARRAY_W = 4,
  parameter int DSP_DLY = 1,
  parameter int TILE_W  = 8,
  parameter int ROW_W   = (ARRAY_H > 1) ? $clog2(ARRAY_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  output logic              weight_buffer_load_en,
  output logic              weight_buffer_out_en,
  output logic              write_weight_en,
  output logic              input_buffer_load_en,
  output logic              input_buffer_out_en,
  output logic              output_buffer_load_en,
  output logic              output_buffer_out_en,
  output logic [ROW_W-1:0]  w_row,
  output logic [ROW_W-1:0]  act_row,
  output logic [ROW_W-1:0]  res_row
`ifdef SYSCTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int SKEW_LEN = DSP_DLY * (ARRAY_W - 1);
  localparam int COLL_LEN = 2 * DSP_DLY * ARRAY_H;
  localparam int MAX_A    = (COLL_LEN > SKEW_LEN) ? COLL_LEN : SKEW_LEN;
  localparam int MAX_LEN  = (MAX_A > ARRAY_H) ? MAX_A : ARRAY_H;
  localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ARRAY_H - 1);
  localparam logic [CNT_W-1:0] LAST_SKEW = CNT_W'((SKEW_LEN > 0) ? SKEW_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_COLL = CNT_W'(COLL_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FEED, S_SKEW, S_COLLECT, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic              start_acc;

  assign start_acc = (state_q == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tile_q   <= '0;
      ntiles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      ntiles_q <= ntiles_d;
    end
  end

  // cnt_q is the in-phase position; it restarts at 0 on every phase change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    ntiles_d = ntiles_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tile_d = '0;
        if (start_acc) begin
          ntiles_d = num_tiles;
          state_d  = (num_tiles == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = S_FEED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FEED: begin
        if (cnt_q == LAST_ROW) begin
          cnt_d   = '0;
          state_d = (SKEW_LEN > 0) ? S_SKEW : S_COLLECT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SKEW: begin
        if (cnt_q == LAST_SKEW) begin
          cnt_d   = '0;
          state_d = S_COLLECT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_COLLECT: begin
        if (cnt_q == LAST_COLL) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // Drain only advances on beats the downstream accepts.
      S_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST_ROW) begin
            cnt_d = '0;
            if (tile_q == ntiles_q - TILE_W'(1)) begin
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + TILE_W'(1);
              state_d = S_LOAD_W;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        tile_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        tile_d  = '0;
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tile_d  = '0;
    end
  end

  assign busy                  = (state_q != S_IDLE);
  assign done                  = (state_q == S_DONE);
  assign tile_idx              = tile_q;
  assign weight_buffer_load_en = (state_q == S_LOAD_W);
  assign weight_buffer_out_en  = (state_q == S_FEED);
  assign write_weight_en       = (state_q == S_FEED);
  assign input_buffer_load_en  = (state_q == S_FEED);
  assign input_buffer_out_en   = (state_q == S_SKEW) || (state_q == S_COLLECT);
  assign output_buffer_load_en = (state_q == S_COLLECT);
  assign output_buffer_out_en  = (state_q == S_DRAIN) && out_ready;
  assign w_row                 = (state_q == S_LOAD_W) ? cnt_q[ROW_W-1:0] : '0;
  assign act_row               = (state_q == S_FEED)   ? cnt_q[ROW_W-1:0] : '0;
  assign res_row               = (state_q == S_DRAIN)  ? cnt_q[ROW_W-1:0] : '0;

`ifdef SYSCTRL_PERF_EN
  // Counters restart with each accepted job and freeze once it is over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (busy) begin
      if (perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
      if ((state_q == S_DRAIN) && !out_ready && (perf_stalls != 32'hFFFF_FFFF))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: job table, random jobs vs a slot-queue model,
// plus reset/abort/W=1 sequences. Perf checks are compiled in with SYSCTRL_PERF_EN.
module tb_systolic_seq_ctrl;
  localparam int H = 4;
  localparam int W = 4;
  localparam int D = 1;

  logic       clk = 1'b0;
  logic       rst, start, abort, out_ready;
  logic [7:0] num_tiles;

  logic       busy, done, wl, wo, ww, il, io, ol, oo;
  logic [7:0] tile_idx;
  logic [1:0] w_row, act_row, res_row;
  logic       busy1, done1, wl1, wo1, ww1, il1, io1, ol1, oo1;
  logic [7:0] tile_idx1;
  logic [1:0] w_row1, act_row1, res_row1;
`ifdef SYSCTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_cycles1, perf_stalls1;
`endif

  systolic_seq_ctrl #(.ARRAY_H(H), .ARRAY_W(W), .DSP_DLY(D), .TILE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
    .out_ready(out_ready), .busy(busy), .done(done), .tile_idx(tile_idx),
    .weight_buffer_load_en(wl), .weight_buffer_out_en(wo), .write_weight_en(ww),
    .input_buffer_load_en(il), .input_buffer_out_en(io), .output_buffer_load_en(ol),
    .output_buffer_out_en(oo), .w_row(w_row), .act_row(act_row), .res_row(res_row)
`ifdef SYSCTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  systolic_seq_ctrl #(.ARRAY_H(H), .ARRAY_W(1), .DSP_DLY(D), .TILE_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
    .out_ready(out_ready), .busy(busy1), .done(done1), .tile_idx(tile_idx1),
    .weight_buffer_load_en(wl1), .weight_buffer_out_en(wo1), .write_weight_en(ww1),
    .input_buffer_load_en(il1), .input_buffer_out_en(io1), .output_buffer_load_en(ol1),
    .output_buffer_out_en(oo1), .w_row(w_row1), .act_row(act_row1), .res_row(res_row1)
`ifdef SYSCTRL_PERF_EN
    , .perf_cycles(perf_cycles1), .perf_stalls(perf_stalls1)
`endif
  );

  always #5 clk = ~clk;

  // Phase codes: 0 idle, 1 LOAD_W, 2 FEED, 3 SKEW, 4 COLLECT, 5 DRAIN, 6 DONE.
  typedef struct {
    int phase;
    int row;
    int tile;
  } slot_t;

  typedef struct {
    int n;
    int stall_row;
    int stall_len;
    int abort_cyc;
    int restart_cyc;
    int exp_busy;
    int exp_done;
    int exp_pcyc;
    int exp_pstall;
  } job_t;

  slot_t q[$];
  int    checks = 0;
  int    errors = 0;

  logic [22:0] act_vec, act_vec1;
  assign act_vec  = {busy, done, tile_idx, wl, wo, ww, il, io, ol, oo, w_row, act_row, res_row};
  assign act_vec1 = {busy1, done1, tile_idx1, wl1, wo1, ww1, il1, io1, ol1, oo1,
                     w_row1, act_row1, res_row1};

  function automatic void push_phase(int ph, int len, int tile);
    for (int i = 0; i < len; i++) begin
      slot_t s;
      s.phase = ph;
      s.row   = i;
      s.tile  = tile;
      q.push_back(s);
    end
  endfunction

  function automatic void build_job(int n);
    if (n == 0) begin
      push_phase(6, 1, 0);
    end else begin
      for (int t = 0; t < n; t++) begin
        push_phase(1, H, t);
        push_phase(2, H, t);
        push_phase(3, D * (W - 1), t);
        push_phase(4, 2 * D * H, t);
        push_phase(5, H, t);
      end
      push_phase(6, 1, n - 1);
    end
  endfunction

  function automatic logic [22:0] exp_vec(bit rdy);
    int ph, row, tile;
    ph = 0; row = 0; tile = 0;
    if (q.size() > 0) begin
      ph = q[0].phase; row = q[0].row; tile = q[0].tile;
    end
    return {ph != 0, ph == 6, 8'(tile), ph == 1, ph == 2, ph == 2, ph == 2,
            (ph == 3) || (ph == 4), ph == 4, (ph == 5) && rdy,
            2'((ph == 1) ? row : 0), 2'((ph == 2) ? row : 0), 2'((ph == 5) ? row : 0)};
  endfunction

  task automatic checkOutput(input string name, input int cyc, input logic [22:0] act,
                             input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one job from idle; called with time just past a rising edge.
  task automatic applyStimulus(input int n, input int stall_row, input int stall_len,
                               input int abort_cyc, input int restart_cyc, input bit rnd,
                               output int busy_cnt, output int done_cnt);
    int stalls;
    bit rdy;
    busy_cnt = 0; done_cnt = 0; stalls = 0;
    num_tiles = 8'(n); start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    #1 checkOutput("pre_start", 0, act_vec, exp_vec(1'b1));
    @(posedge clk); #1;
    start = 1'b0;
    build_job(n);
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (rnd) begin
        rdy = ($urandom_range(3) != 0);
      end else begin
        rdy = 1'b1;
        if (q.size() > 0 && q[0].phase == 5 && q[0].row == stall_row && stalls < stall_len) begin
          rdy = 1'b0;
          stalls++;
        end
      end
      out_ready = rdy;
      abort     = (cyc == abort_cyc);
      start     = (cyc == restart_cyc);
      if (start) num_tiles = 8'($urandom_range(5));
      #1 checkOutput("cycle", cyc, act_vec, exp_vec(rdy));
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (abort) q.delete();
      else if (q.size() > 0 && !(q[0].phase == 5 && !rdy)) q.delete(0);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      if (q.size() == 0) begin
        #1 checkOutput("idle_after", cyc + 1, act_vec, exp_vec(1'b1));
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL job_timeout: got still busy expected idle within 3000 cycles");
  endtask

  job_t jobs[6];
  int   bc, dc;

  initial begin
    jobs[0] = '{1, -1, 0, -1, -1, 24, 1, 24, 0};
    jobs[1] = '{3, -1, 0, -1, -1, 70, 1, 70, 0};
    jobs[2] = '{1,  2, 5, -1, -1, 29, 1, 29, 5};
    jobs[3] = '{1, -1, 0, 14, -1, 14, 0, 14, 0};
    jobs[4] = '{0, -1, 0, -1, -1,  1, 1,  1, 0};
    jobs[5] = '{1, -1, 0, -1, 10, 24, 1, 24, 0};

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; num_tiles = 8'd0;
    #12;
    checkOutput("reset_state", 0, act_vec, 23'd0);
    checkOutput("reset_state_w1", 0, act_vec1, 23'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 6; j++) begin
      applyStimulus(jobs[j].n, jobs[j].stall_row, jobs[j].stall_len, jobs[j].abort_cyc,
                    jobs[j].restart_cyc, 1'b0, bc, dc);
      checkInt($sformatf("job%0d_busy_cycles", j), bc, jobs[j].exp_busy);
      checkInt($sformatf("job%0d_done_pulses", j), dc, jobs[j].exp_done);
`ifdef SYSCTRL_PERF_EN
      checkInt($sformatf("job%0d_perf_cycles", j), int'(perf_cycles), jobs[j].exp_pcyc);
      checkInt($sformatf("job%0d_perf_stalls", j), int'(perf_stalls), jobs[j].exp_pstall);
`endif
    end

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; num_tiles = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1 checkOutput("start_with_abort", 1, act_vec, 23'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++) begin
      int n, ab;
      n  = $urandom_range(3);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(60, 1)) : -1;
      applyStimulus(n, -1, 0, ab, int'($urandom_range(15, 2)), 1'b1, bc, dc);
    end

    // Asynchronous reset in the middle of FEED.
    num_tiles = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    build_job(2);
    for (int c = 1; c <= 6; c++) begin
      #1 checkOutput("pre_reset", c, act_vec, exp_vec(1'b1));
      q.delete(0);
      @(posedge clk); #1;
    end
    #1 checkOutput("feed_before_reset", 7, act_vec, exp_vec(1'b1));
    #2 rst = 1'b0;
    q.delete();
    #1 checkOutput("async_reset", 7, act_vec, 23'd0);
    checkOutput("async_reset_w1", 7, act_vec1, 23'd0);
    @(posedge clk); #1;
    checkOutput("held_in_reset", 8, act_vec, 23'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // W=1 instance skips SKEW: 20 phase cycles, 8 cycles of input_buffer_out_en.
    begin
      int ph1, io_cnt, d1;
      ph1 = 0; io_cnt = 0; d1 = 0;
      num_tiles = 8'd1; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (busy1 && !done1) ph1++;
        if (io1) io_cnt++;
        if (done1) d1++;
        @(posedge clk); #1;
      end
      checkInt("w1_phase_cycles", ph1, 20);
      checkInt("w1_skew_collect_cycles", io_cnt, 8);
      checkInt("w1_done_pulses", d1, 1);
`ifdef SYSCTRL_PERF_EN
      checkInt("w1_perf_cycles", int'(perf_cycles1), 21);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
